// File: rtl/id_ex_skid_reg.sv
// ID/EX elastic pipeline stage: valid/ready handshake with a two-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one beat of
// execute back-pressure), synchronous bubble-inserting flush, and a
// saturating back-pressure cycle counter.
module id_ex_skid_reg #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clkIn,
  input  logic              resetn,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [RD_W-1:0]   rdIn,
  input  logic [XLEN-1:0]   AddrIn,
  input  logic [XLEN-1:0]   ImmIn,
  input  logic [XLEN-1:0]   Data1In,
  input  logic [XLEN-1:0]   Data2In,
  input  logic [CTRL_W-1:0] ctrSignalsIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [RD_W-1:0]   rdOut,
  output logic [XLEN-1:0]   AddrOut,
  output logic [XLEN-1:0]   ImmOut,
  output logic [XLEN-1:0]   Data1Out,
  output logic [XLEN-1:0]   Data2Out,
  output logic [CTRL_W-1:0] ctrSignalsOut,
  output logic [CNT_W-1:0]  stallCount
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  payload_t   main_q, skid_q, in_pl;
  logic       main_vld, skid_vld, rdy_q;
  logic       in_fire, out_fire;
  logic [CNT_W-1:0] stall_q;

  assign in_pl    = '{rd: rdIn, addr: AddrIn, imm: ImmIn, d1: Data1In,
                      d2: Data2In, ctrl: ctrSignalsIn};
  assign in_fire  = inValid & rdy_q;
  assign out_fire = main_vld & outReady;

  // Handshake FSM; valid/ready flags are registered alongside the state so
  // inReady never depends combinationally on outReady.
  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      // Bubble: all-zero payload/control, any incoming beat is dropped.
      state    <= EMPTY;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q   <= in_pl;
            main_vld <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_pl;
          end else if (in_fire) begin
            skid_q   <= in_pl;
            skid_vld <= 1'b1;
            rdy_q    <= 1'b0;
            state    <= FULL;
          end else if (out_fire) begin
            // Payload is left as-is; consumers qualify with outValid.
            main_vld <= 1'b0;
            state    <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles where execute stalls a valid output; only
  // reset clears it.
  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn)
      stall_q <= '0;
    else if (main_vld && !outReady && stall_q != CNT_MAX)
      stall_q <= stall_q + 1'b1;
  end

  assign inReady       = rdy_q;
  assign outValid      = main_vld;
  assign rdOut         = main_q.rd;
  assign AddrOut       = main_q.addr;
  assign ImmOut        = main_q.imm;
  assign Data1Out      = main_q.d1;
  assign Data2Out      = main_q.d2;
  assign ctrSignalsOut = main_q.ctrl;
  assign stallCount    = stall_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg: a default-width instance for handshake,
// skid and flush behaviour, and a wide instance (CNT_W=4) for width and
// counter saturation.
module tb_id_ex_skid_reg;

  logic clkIn = 1'b0;
  logic resetn;
  always #5 clkIn = ~clkIn;

  int errs = 0;
  int checks = 0;

  // default-width instance
  logic        flush, inValid, inReady, outValid, outReady;
  logic [4:0]  rdIn, rdOut;
  logic [31:0] AddrIn, ImmIn, Data1In, Data2In;
  logic [31:0] AddrOut, ImmOut, Data1Out, Data2Out;
  logic [11:0] ctrIn, ctrOut;
  logic [15:0] stall;

  id_ex_skid_reg u_dut (
    .clkIn(clkIn), .resetn(resetn), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .rdIn(rdIn), .AddrIn(AddrIn), .ImmIn(ImmIn), .Data1In(Data1In),
    .Data2In(Data2In), .ctrSignalsIn(ctrIn),
    .outValid(outValid), .outReady(outReady),
    .rdOut(rdOut), .AddrOut(AddrOut), .ImmOut(ImmOut), .Data1Out(Data1Out),
    .Data2Out(Data2Out), .ctrSignalsOut(ctrOut), .stallCount(stall)
  );

  // wide instance
  logic        w_flush, w_inValid, w_inReady, w_outValid, w_outReady;
  logic [5:0]  w_rdIn, w_rdOut;
  logic [63:0] w_addrIn, w_immIn, w_d1In, w_d2In;
  logic [63:0] w_addrOut, w_immOut, w_d1Out, w_d2Out;
  logic [19:0] w_ctrIn, w_ctrOut;
  logic [3:0]  w_stall;

  id_ex_skid_reg #(.XLEN(64), .RD_W(6), .CTRL_W(20), .CNT_W(4)) u_wide (
    .clkIn(clkIn), .resetn(resetn), .flush(w_flush),
    .inValid(w_inValid), .inReady(w_inReady),
    .rdIn(w_rdIn), .AddrIn(w_addrIn), .ImmIn(w_immIn), .Data1In(w_d1In),
    .Data2In(w_d2In), .ctrSignalsIn(w_ctrIn),
    .outValid(w_outValid), .outReady(w_outReady),
    .rdOut(w_rdOut), .AddrOut(w_addrOut), .ImmOut(w_immOut), .Data1Out(w_d1Out),
    .Data2Out(w_d2Out), .ctrSignalsOut(w_ctrOut), .stallCount(w_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; outputs are stable here
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    flush = 0; inValid = 0; outReady = 0;
    rdIn = 0; AddrIn = 0; ImmIn = 0; Data1In = 0; Data2In = 0; ctrIn = 0;
    w_flush = 0; w_inValid = 0; w_outReady = 0;
    w_rdIn = 0; w_addrIn = 0; w_immIn = 0; w_d1In = 0; w_d2In = 0; w_ctrIn = 0;
    repeat (2) tick();
    resetn = 1'b1;

    // load one beat and stall a cycle, then reset asynchronously mid-cycle
    inValid = 1; AddrIn = 32'h50; ctrIn = 12'hABC; outReady = 0;
    tick();
    chk("pre_vld", outValid, 1);
    inValid = 0;
    tick();
    chk("pre_stall", stall, 1);
    #3 resetn = 1'b0;
    #1;
    chk("rst_vld", outValid, 0);
    chk("rst_rdy", inReady, 1);
    chk("rst_ctrl", ctrOut, 0);
    chk("rst_addr", AddrOut, 0);
    chk("rst_stall", stall, 0);
    tick();
    resetn = 1'b1;

    // streaming at full throughput
    outReady = 1; inValid = 1; AddrIn = 32'h100; ctrIn = 12'h001;
    tick();
    chk("str0_vld", outValid, 1);
    chk("str0_addr", AddrOut, 32'h100);
    AddrIn = 32'h104;
    tick();
    chk("str1_vld", outValid, 1);
    chk("str1_addr", AddrOut, 32'h104);
    AddrIn = 32'h108;
    tick();
    chk("str2_vld", outValid, 1);
    chk("str2_addr", AddrOut, 32'h108);
    inValid = 0;
    tick();
    chk("str_drain_vld", outValid, 0);
    chk("str_hold_addr", AddrOut, 32'h108);

    // skid: outReady low for the second cycle only
    inValid = 1; AddrIn = 32'h200; outReady = 1;
    tick();
    chk("sk0_addr", AddrOut, 32'h200);
    chk("sk0_rdy", inReady, 1);
    AddrIn = 32'h204; outReady = 0;
    tick();
    chk("sk1_addr", AddrOut, 32'h200);
    chk("sk1_rdy", inReady, 0);
    chk("sk1_stall", stall, 1);
    AddrIn = 32'h208; outReady = 1;
    tick();
    chk("sk2_addr", AddrOut, 32'h204);
    chk("sk2_rdy", inReady, 1);
    tick();
    chk("sk3_addr", AddrOut, 32'h208);
    chk("sk3_vld", outValid, 1);
    inValid = 0;
    tick();
    chk("sk_drain_vld", outValid, 0);
    chk("sk_stall", stall, 1);

    // flush while FULL, with a same-cycle incoming beat
    outReady = 0; inValid = 1; ctrIn = 12'hABC; AddrIn = 32'h300;
    tick();
    chk("fl0_vld", outValid, 1);
    AddrIn = 32'h304;
    tick();
    chk("fl1_rdy", inReady, 0);
    chk("fl1_stall", stall, 2);
    flush = 1; AddrIn = 32'h308;
    tick();
    chk("fl_vld", outValid, 0);
    chk("fl_ctrl", ctrOut, 0);
    chk("fl_addr", AddrOut, 0);
    chk("fl_rdy", inReady, 1);
    flush = 0; inValid = 0; outReady = 1;
    tick();
    chk("fl_after_vld", outValid, 0);
    chk("fl_stall", stall, 3);

    // width generality on the wide instance
    w_outReady = 1; w_inValid = 1;
    w_d1In = 64'hFFFF_FFFF_0000_0001; w_rdIn = 6'h3F; w_ctrIn = 20'hF00F5;
    w_addrIn = 64'h8000_0000_0000_0100;
    tick();
    chk("w_d1", w_d1Out, 64'hFFFF_FFFF_0000_0001);
    chk("w_rd", {58'd0, w_rdOut}, 64'h3F);
    chk("w_ctrl", {44'd0, w_ctrOut}, 64'hF00F5);
    w_d1In = 64'h0123_4567_89AB_CDEF; w_addrIn = 64'h8000_0000_0000_0104;
    tick();
    chk("w_d1b", w_d1Out, 64'h0123_4567_89AB_CDEF);
    chk("w_addr", w_addrOut, 64'h8000_0000_0000_0104);

    // counter saturation with CNT_W=4: held beat, outReady low
    w_outReady = 0;
    tick();
    w_inValid = 0;
    // the edge above counted one stall (valid beat, not ready)
    chk("w_stall1", {60'd0, w_stall}, 1);
    repeat (9) tick();
    chk("w_stall10", {60'd0, w_stall}, 10);
    repeat (10) tick();
    chk("w_stall_sat", {60'd0, w_stall}, 15);
    w_flush = 1;
    tick();
    w_flush = 0;
    chk("w_flush_vld", w_outValid, 0);
    chk("w_flush_stall", {60'd0, w_stall}, 15);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised, elastic ID/EX pipeline stage for the five-stage core: it carries rd, PC, immediate, two register operands and the control word from decode to execute. Unlike a plain edge register, it implements a valid/ready handshake with a two-entry skid buffer so execute back-pressure never loses an instruction. It also has a synchronous flush that inserts a bubble with all-zero control, and a saturating back-pressure cycle counter. It sits between the decode/register-file logic and the ALU/forwarding logic.

## Interface
Parameters:
- XLEN, 32, width of AddrIn/ImmIn/Data1In/Data2In and matching outputs
- RD_W, 5, width of rdIn/rdOut
- CTRL_W, 12, width of ctrSignalsIn/ctrSignalsOut
- CNT_W, 16, width of stallCount

Ports:
- clkIn  input  1  single clock; all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held and incoming entries
- inValid  input  1  decode presents a valid instruction
- inReady  output  1  stage can accept this cycle (registered)
- rdIn, AddrIn, ImmIn, Data1In, Data2In, ctrSignalsIn  input  RD_W/XLEN/XLEN/XLEN/XLEN/CTRL_W  decode payload
- outValid  output  1  output payload holds a valid instruction
- outReady  input  1  execute accepts this cycle
- rdOut, AddrOut, ImmOut, Data1Out, Data2Out, ctrSignalsOut  output  same widths  execute payload (main entry)
- stallCount  output  CNT_W  saturating count of back-pressured cycles

## Operation
- inFire = inValid & inReady; outFire = outValid & outReady.
- Storage: main entry (drives outputs directly) + skid entry, each with a valid bit. Three states:
  - EMPTY: inFire -> main<=in, go ONE.
  - ONE: inFire&outFire -> main<=in, stay ONE. inFire&~outFire -> skid<=in, go FULL. ~inFire&outFire -> go EMPTY. Neither -> hold.
  - FULL: inReady=0 so no inFire. outFire -> main<=skid, go ONE. Else hold.
- inReady = ~skidValid, taken from a register, never combinational from outReady.
- Flush has highest priority over all transitions:
  - Next state is EMPTY.
  - outValid and skid valid go to 0; ctrSignalsOut and all payload outputs go to 0, which is a NOP bubble.
  - Any same-cycle inFire is dropped.
  - stallCount is unaffected.
- When the stage goes EMPTY by consumption, the payload outputs hold their last value. Consumers must qualify them with outValid.
- stallCount increments by 1 each cycle with outValid=1 and outReady=0. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Asynchronous reset, active-low:
  - outValid=0, inReady=1, skid valid=0, stallCount=0.
  - rdOut, AddrOut, ImmOut, Data1Out, Data2Out, ctrSignalsOut = 0.
- All register updates use nonblocking assignment. No output is a combinational function of outReady.

## Timing
- Latency: an instruction accepted at edge N appears with outValid=1 after edge N.
- Throughput: one instruction per cycle while outReady=1.
- Back-pressure:
  - outReady low for one cycle with inValid high fills the skid; inReady drops after that edge.
  - The first outReady=1 cycle moves skid to main; inReady rises after the same edge.
  - No beat is lost or duplicated.
- Ordering: strictly FIFO; skid is never overtaken by the input.
- Flush applies on the edge where it is sampled high. In the following cycle outValid=0 and inReady=1.
- resetn deassertion mid-stream: the first accepted instruction appears one edge after its inFire, as in EMPTY.

## Test plan
- Reset: resetn=0 asynchronously mid-cycle -> immediately outValid=0, inReady=1, ctrSignalsOut=0, stallCount=0.
- Streaming: inValid=1, outReady=1, AddrIn=0x100,0x104,0x108 on consecutive cycles -> AddrOut shows 0x100,0x104,0x108 one cycle later each, outValid constant 1.
- Skid: stream 0x200,0x204,0x208 with outReady=0 on the second cycle only -> inReady=0 for exactly one cycle; execute receives 0x200,0x204,0x208 in order, no duplicates; stallCount=1.
- Flush in FULL: fill both entries with ctrSignalsIn=0xABC, then flush=1 with inValid=1 -> next cycle outValid=0, ctrSignalsOut=0, inReady=1; the flushed and incoming beats never appear.
- Saturation: CNT_W=4, outValid=1, outReady=0 for 20 cycles -> stallCount=15 and holds there; flush leaves it at 15.
- Width generality: XLEN=64, RD_W=6, CTRL_W=20, run streaming with Data1In=0xFFFF_FFFF_0000_0001 -> Data1Out matches bit-exactly.
